vca_scheduler: RTL and testbench

VCA_SCHEDULER -- requirements
Module: vca_scheduler

---
 rtl/vca_scheduler.sv | 141 ++++++++++++++
 tb/tb_vca_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vca_scheduler.sv
// ============================================================================
// vca_scheduler -- time-multiplexed VCA: one shared 17x17 multiplier per voice
// per cycle, 2-stage pipeline, saturating mix bus.   Rev 1.0
// ============================================================================
`default_nettype none

module vca_scheduler #(
    parameter int VOICES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic [VOICES*32-1:0]  voice_in,
    input  logic [VOICES*32-1:0]  voice_cv,
    input  logic [VOICES-1:0]     voice_en,
    input  logic                  overrun_clr,
    output logic [VOICES*32-1:0]  voice_out,
    output logic [31:0]           mix_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(VOICES - 1);
    localparam logic signed [36:0] ACC_MAX = 37'sh00_7FFF_FFFF;
    localparam logic signed [36:0] ACC_MIN = 37'sh1F_8000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [31:0]            p_q;
    logic [IW-1:0]          p_idx_q;
    logic                   p_vld_q;
    logic signed [36:0]     acc_q;
    logic [VOICES*32-1:0]   voice_out_q;
    logic [31:0]            mix_q;
    logic                   done_q;
    logic                   overrun_q;

    logic [31:0]            in_sel;
    logic [31:0]            cv_sel;
    logic signed [16:0]     s_in;
    logic signed [16:0]     s_cv;
    logic signed [33:0]     prod;
    logic [31:0]            p_d;
    logic signed [36:0]     sat;
    logic [31:0]            mix_d;

    // Offset-binary to signed: subtracting 32768 just flips the MSB.
    always_comb begin
        in_sel = voice_in[{idx_q, 5'b00000} +: 32];
        cv_sel = voice_cv[{idx_q, 5'b00000} +: 32];
        s_in   = {~in_sel[31], ~in_sel[31], in_sel[30:16]};
        s_cv   = {1'b0, cv_sel[31:16]};
        prod   = s_in * s_cv;
        p_d    = voice_en[idx_q] ? prod[31:0] : 32'd0;
    end

    always_comb begin
        sat = acc_q;
        if (acc_q > ACC_MAX) begin
            sat = ACC_MAX;
        end else if (acc_q < ACC_MIN) begin
            sat = ACC_MIN;
        end
        mix_d = sat[31:0] ^ 32'h8000_0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            p_q         <= '0;
            p_idx_q     <= '0;
            p_vld_q     <= 1'b0;
            acc_q       <= '0;
            voice_out_q <= {VOICES{32'h8000_0000}};
            mix_q       <= 32'h8000_0000;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            p_vld_q <= 1'b0;

            if (sample_tick && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            if (p_vld_q) begin
                voice_out_q[{p_idx_q, 5'b00000} +: 32] <= p_q ^ 32'h8000_0000;
                acc_q <= acc_q + {{5{p_q[31]}}, p_q};
            end

            case (state_q)
                S_IDLE: begin
                    if (sample_tick) begin
                        state_q <= S_RUN;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                S_RUN: begin
                    p_q     <= p_d;
                    p_idx_q <= idx_q;
                    p_vld_q <= 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DRAIN;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_DRAIN: state_q <= S_DONE;
                S_DONE: begin
                    state_q <= S_IDLE;
                    mix_q   <= mix_d;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign voice_out = voice_out_q;
    assign mix_out   = mix_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vca_scheduler.sv
// ============================================================================
// tb_vca_scheduler -- directed self-checking bench for vca_scheduler (8 voices).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vca_scheduler;

    localparam int V = 8;

    logic           clk;
    logic           rst_n;
    logic           sample_tick;
    logic [V*32-1:0] voice_in;
    logic [V*32-1:0] voice_cv;
    logic [V-1:0]   voice_en;
    logic           overrun_clr;
    logic [V*32-1:0] voice_out;
    logic [31:0]    mix_out;
    logic           busy;
    logic           done;
    logic           overrun;

    int n_pass;
    int n_total;

    vca_scheduler #(.VOICES(V)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .voice_in    (voice_in),
        .voice_cv    (voice_cv),
        .voice_en    (voice_en),
        .overrun_clr (overrun_clr),
        .voice_out   (voice_out),
        .mix_out     (mix_out),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_voices(input string tag, input logic [V*32-1:0] exp);
        for (int k = 0; k < V; k++) begin
            check($sformatf("%s_v%0d", tag, k), voice_out[k*32 +: 32], exp[k*32 +: 32]);
        end
    endtask

    // Pulse a tick at the next edge (E0) and count edges until done is seen.
    task automatic run_frame(output int lat);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            lat++;
            if (done) break;
        end
    endtask

    int lat;
    int ndone;

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        voice_in = '0;
        voice_cv = '0;
        voice_en = '0;
        #12;

        // Reset values
        check_voices("rst", {V{32'h8000_0000}});
        check("rst_mix", mix_out, 32'h8000_0000);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Full scale: saturating mix, done 10 edges after the tick edge
        voice_in = {V{32'hFFFF_0000}};
        voice_cv = {V{32'hFFFF_0000}};
        voice_en = 8'hFF;
        run_frame(lat);
        check("fs_latency", lat, 32'd10);
        check_voices("fs", {V{32'hFFFE_8001}});
        check("fs_mix", mix_out, 32'hFFFF_FFFF);
        step();
        check("fs_done_width", {31'd0, done}, 32'd0);
        check("fs_busy_idle", {31'd0, busy}, 32'd0);

        // Most negative input, cv = 1
        voice_in = {V{32'h0000_0000}};
        voice_cv = {V{32'h0001_0000}};
        voice_en = 8'hFF;
        run_frame(lat);
        check("neg_latency", lat, 32'd10);
        check_voices("neg", {V{32'h7FFF_8000}});
        check("neg_mix", mix_out, 32'h7FFC_0000);

        // Enable mask: only voice 0
        voice_in = {V{32'hFFFF_0000}};
        voice_in[31:0] = 32'hC000_0000;
        voice_cv = {V{32'h8000_0000}};
        voice_en = 8'h01;
        run_frame(lat);
        check_voices("mask", {{(V-1){32'h8000_0000}}, 32'hA000_0000});
        check("mask_mix", mix_out, 32'hA000_0000);

        // Overrun: second tick three edges into the frame
        voice_in = {V{32'hA000_0000}};
        voice_cv = {V{32'h0004_0000}};
        voice_en = 8'hFF;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("ovr_set", {31'd0, overrun}, 32'd1);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (done) ndone++;
        end
        check("ovr_done_count", ndone, 32'd1);
        check_voices("ovr", {V{32'h8000_8000}});
        check("ovr_mix", mix_out, 32'h8004_0000);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // Set and clear together while busy: set wins
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        step();
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        check("ovr_set_wins", {31'd0, overrun}, 32'd1);
        for (int c = 0; c < 20; c++) step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;

        // Back-to-back: tick lands in the done cycle
        voice_in = {V{32'hFFFF_0000}};
        voice_cv = {V{32'hFFFF_0000}};
        run_frame(lat);
        check("b2b_first_latency", lat, 32'd10);
        check("b2b_first_mix", mix_out, 32'hFFFF_FFFF);
        voice_in = {V{32'h0000_0000}};
        voice_cv = {V{32'h0001_0000}};
        run_frame(lat);
        check("b2b_second_latency", lat, 32'd10);
        check("b2b_no_overrun", {31'd0, overrun}, 32'd0);
        check("b2b_second_mix", mix_out, 32'h7FFC_0000);
        check_voices("b2b", {V{32'h7FFF_8000}});
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        for (int c = 0; c < 15; c++) step();

        // Abort by reset during RUN
        voice_in = {V{32'hFFFF_0000}};
        voice_cv = {V{32'hFFFF_0000}};
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_voices("abort", {V{32'h8000_0000}});
        check("abort_mix", mix_out, 32'h8000_0000);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done || busy) ndone++;
        end
        check("abort_no_done", ndone, 32'd0);
        check("abort_mix_held", mix_out, 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
